// File: rtl/vga_bounce_box.sv
// Pixel stage after the 640x480 sync generator: draws a bouncing box
// and re-times rgb/hsync/vsync one pixel late.
//
// Ports:
//   clk, reset (async, active-high)
//   p_tick, video_on, hsync_in, vsync_in, pixel_x, pixel_y: sync-gen inputs
//   pause: freezes motion, sampled at the frame tick
//   rgb, hsync_out, vsync_out: registered pixel outputs
//   frame_tick: one-clk pulse per frame
//   box_x, box_y: box top-left corner
//
// Optional build macro BOX_BORDER_EN: paints the box outline 12'hFFF.
module vga_bounce_box #(
  parameter int          HD      = 640,
  parameter int          VD      = 480,
  parameter int          SIZE    = 32,
  parameter int          SPEED   = 2,
  parameter int          X0      = 100,
  parameter int          Y0      = 100,
  parameter logic [11:0] BOX_RGB = 12'hF00,
  parameter logic [11:0] BG_RGB  = 12'h00F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  typedef enum logic [1:0] {
    RD = 2'b00,
    RU = 2'b01,
    LD = 2'b10,
    LU = 2'b11
  } dir_e;

  localparam logic [10:0] XMAX = 11'(HD - SIZE);
  localparam logic [10:0] YMAX = 11'(VD - SIZE);
  localparam logic [10:0] SPD  = 11'(SPEED);
  localparam logic [10:0] SZM1 = 11'(SIZE - 1);
  localparam logic [9:0]  TOPV = 10'(VD);

  dir_e        state_q, state_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        tick_q, tick_d;

  logic [10:0] px, py, bx, by, bx_end, by_end;
  logic        in_box;
  logic [11:0] colour;

  // Widened to 11 bits so box_x+SIZE-1 cannot wrap.
  always_comb begin
    px     = {1'b0, pixel_x};
    py     = {1'b0, pixel_y};
    bx     = {1'b0, box_x_q};
    by     = {1'b0, box_y_q};
    bx_end = bx + SZM1;
    by_end = by + SZM1;
    in_box = (px >= bx) && (px <= bx_end) &&
             (py >= by) && (py <= by_end);
    colour = 12'h000;
    if (video_on) begin
      if (in_box) begin
`ifdef BOX_BORDER_EN
        if (px == bx || px == bx_end ||
            py == by || py == by_end)
          colour = 12'hFFF;
        else
          colour = BOX_RGB;
`else
        colour = BOX_RGB;
`endif
      end else begin
        colour = BG_RGB;
      end
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (p_tick) begin
      rgb_d = colour;
      hs_d  = hsync_in;
      vs_d  = vsync_in;
    end
  end

  // First blanking line: moving the box here never tears the image.
  always_comb begin
    tick_d = p_tick && (pixel_x == 10'd0) &&
             (pixel_y == TOPV);
  end

  logic left, up, nleft, nup;

  always_comb begin
    left    = 1'b0;
    up      = 1'b0;
    unique case (state_q)
      RD: begin left = 1'b0; up = 1'b0; end
      RU: begin left = 1'b0; up = 1'b1; end
      LD: begin left = 1'b1; up = 1'b0; end
      LU: begin left = 1'b1; up = 1'b1; end
      default: begin left = 1'b0; up = 1'b0; end
    endcase
    nleft   = left;
    nup     = up;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    state_d = state_q;
    if (tick_q && !pause) begin
      if (!left) begin
        if (bx + SPD > XMAX) begin
          box_x_d = XMAX[9:0];
          nleft   = 1'b1;
        end else begin
          box_x_d = box_x_q + SPD[9:0];
        end
      end else begin
        if (bx < SPD) begin
          box_x_d = 10'd0;
          nleft   = 1'b0;
        end else begin
          box_x_d = box_x_q - SPD[9:0];
        end
      end
      if (!up) begin
        if (by + SPD > YMAX) begin
          box_y_d = YMAX[9:0];
          nup     = 1'b1;
        end else begin
          box_y_d = box_y_q + SPD[9:0];
        end
      end else begin
        if (by < SPD) begin
          box_y_d = 10'd0;
          nup     = 1'b0;
        end else begin
          box_y_d = box_y_q - SPD[9:0];
        end
      end
      state_d = dir_e'({nleft, nup});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RD;
      box_x_q <= 10'(X0);
      box_y_q <= 10'(Y0);
      rgb_q   <= 12'h000;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      tick_q  <= tick_d;
    end
  end

  assign rgb        = rgb_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign frame_tick = tick_q;
  assign box_x      = box_x_q;
  assign box_y      = box_y_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: pixel table with a scoreboard queue,
// plus frame-level motion, pause, reset and corner sequences.
module tb_vga_bounce_box;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, video_on, hsync_in, vsync_in, pause;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_tick;
  logic [9:0]  box_x, box_y;

  logic [11:0] e_rgb;
  logic        e_hs, e_vs, e_tick;
  logic [9:0]  e_bx, e_by;

  logic        s_tick;
  logic [9:0]  s_px, s_py;
  logic [11:0] s_rgb;
  logic        s_hs, s_vs, s_ft;
  logic [9:0]  s_bx, s_by;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_bounce_box u_dut (
    .clk(clk), .reset(reset), .p_tick(p_tick),
    .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pause(pause), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_tick(frame_tick), .box_x(box_x), .box_y(box_y)
  );

  vga_bounce_box #(.SPEED(4), .X0(600)) u_edge (
    .clk(clk), .reset(reset), .p_tick(p_tick),
    .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pause(pause), .rgb(e_rgb),
    .hsync_out(e_hs), .vsync_out(e_vs),
    .frame_tick(e_tick), .box_x(e_bx), .box_y(e_by)
  );

  vga_bounce_box #(
    .HD(40), .VD(40), .SIZE(32), .SPEED(4), .X0(4), .Y0(4)
  ) u_small (
    .clk(clk), .reset(reset), .p_tick(s_tick),
    .video_on(1'b0), .hsync_in(1'b0), .vsync_in(1'b0),
    .pixel_x(s_px), .pixel_y(s_py), .pause(1'b0),
    .rgb(s_rgb), .hsync_out(s_hs), .vsync_out(s_vs),
    .frame_tick(s_ft), .box_x(s_bx), .box_y(s_by)
  );

`ifdef BOX_BORDER_EN
  localparam logic [11:0] EDGE_RGB = 12'hFFF;
`else
  localparam logic [11:0] EDGE_RGB = 12'hF00;
`endif

  typedef struct {
    int          x;
    int          y;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  vec_t tbl[12];
  exp_t expq[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_pix(vec_t v);
    exp_t e;
    pixel_x  = 10'(v.x);
    pixel_y  = 10'(v.y);
    video_on = v.von;
    hsync_in = v.hs;
    vsync_in = v.vs;
    p_tick   = 1'b1;
    e.rgb = v.rgb;
    e.hs  = v.hs;
    e.vs  = v.vs;
    expq.push_back(e);
    @(posedge clk);
    #1;
    p_tick = 1'b0;
  endtask

  task automatic score(string nm);
    exp_t e;
    if (expq.size() == 0) begin
      chk({nm, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      chk({nm, "_rgb"}, rgb, e.rgb);
      chk({nm, "_hs"}, hsync_out, e.hs);
      chk({nm, "_vs"}, vsync_out, e.vs);
    end
  endtask

  task automatic frame_main();
    pixel_x  = 10'd0;
    pixel_y  = 10'd480;
    video_on = 1'b0;
    p_tick   = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    chk("ftick_set", frame_tick, 1);
    pixel_y = 10'd10;
    @(posedge clk);
    #1;
    chk("ftick_clr", frame_tick, 0);
  endtask

  task automatic frame_small();
    s_px   = 10'd0;
    s_py   = 10'd40;
    s_tick = 1'b1;
    @(posedge clk);
    #1;
    s_tick = 1'b0;
    s_py   = 10'd5;
    @(posedge clk);
    #1;
  endtask

  int ex_edge[4];
  int ex_sx[6];
  int ex_sy[6];
  int nticks;
  logic [9:0] bx0, by0;

  initial begin
    tbl[0]  = '{100, 100, 1'b1, 1'b1, 1'b0, EDGE_RGB};
    tbl[1]  = '{132, 100, 1'b1, 1'b0, 1'b1, 12'h00F};
    tbl[2]  = '{100, 100, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[3]  = '{101, 101, 1'b1, 1'b0, 1'b0, 12'hF00};
    tbl[4]  = '{131, 131, 1'b1, 1'b1, 1'b0, EDGE_RGB};
    tbl[5]  = '{131, 100, 1'b1, 1'b0, 1'b1, EDGE_RGB};
    tbl[6]  = '{99,  100, 1'b1, 1'b1, 1'b1, 12'h00F};
    tbl[7]  = '{100, 132, 1'b1, 1'b0, 1'b0, 12'h00F};
    tbl[8]  = '{115, 120, 1'b1, 1'b1, 1'b0, 12'hF00};
    tbl[9]  = '{0,   0,   1'b1, 1'b0, 1'b1, 12'h00F};
    tbl[10] = '{639, 479, 1'b1, 1'b1, 1'b1, 12'h00F};
    tbl[11] = '{700, 300, 1'b0, 1'b0, 1'b0, 12'h000};
    ex_edge = '{604, 608, 608, 604};
    ex_sx   = '{8, 8, 4, 0, 0, 4};
    ex_sy   = '{8, 8, 4, 0, 0, 4};

    reset = 1'b1;
    p_tick = 1'b0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; pause = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0;
    s_tick = 1'b0; s_px = 10'd0; s_py = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_hs", hsync_out, 0);
    chk("rst_vs", vsync_out, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_bx", box_x, 100);
    chk("rst_by", box_y, 100);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive_pix(tbl[i]);
      score($sformatf("pix%0d", i));
    end

    // Outputs hold while p_tick is low.
    drive_pix(tbl[0]);
    score("hold_a");
    pixel_x = 10'd500; video_on = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_rgb", rgb, EDGE_RGB);
    chk("hold_hs", hsync_out, 1);
    chk("hold_vs", vsync_out, 0);

    for (int f = 0; f < 4; f++) begin
      frame_main();
      chk($sformatf("edge_x%0d", f), e_bx, 32'(ex_edge[f]));
      chk($sformatf("edge_y%0d", f), e_by, 32'(100 + 4 * (f + 1)));
      chk($sformatf("main_x%0d", f), box_x, 32'(100 + 2 * (f + 1)));
      chk($sformatf("main_y%0d", f), box_y, 32'(100 + 2 * (f + 1)));
    end

    // Reset mid-frame while frame_tick and outputs are live.
    hsync_in = 1'b1; vsync_in = 1'b1;
    pixel_x = 10'd0; pixel_y = 10'd480; p_tick = 1'b1;
    @(posedge clk);
    #2;
    p_tick = 1'b0;
    chk("pre_rst_tick", frame_tick, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_hs", hsync_out, 0);
    chk("mid_rst_vs", vsync_out, 0);
    chk("mid_rst_tick", frame_tick, 0);
    chk("mid_rst_bx", box_x, 100);
    chk("mid_rst_by", box_y, 100);
    chk("mid_rst_ex", e_bx, 600);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    pixel_y = 10'd10;
    @(posedge clk);
    #1;

    // Sweep the lines around the frame-tick point.
    bx0 = box_x;
    by0 = box_y;
    nticks = 0;
    for (int y = 478; y < 482; y++) begin
      for (int x = 0; x < 800; x++) begin
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = (x < 640) && (y < 480);
        p_tick   = 1'b1;
        @(posedge clk);
        #1;
        if (frame_tick) nticks++;
      end
    end
    p_tick = 1'b0;
    @(posedge clk);
    #1;
    chk("sweep_ticks", nticks, 1);
    chk("sweep_bx", box_x, 32'(bx0) + 2);
    chk("sweep_by", box_y, 32'(by0) + 2);

    // Pause over two frames, release mid-frame.
    bx0 = box_x;
    by0 = box_y;
    pause = 1'b1;
    for (int f = 0; f < 2; f++) begin
      frame_main();
      chk($sformatf("pause_x%0d", f), box_x, bx0);
      chk($sformatf("pause_y%0d", f), box_y, by0);
    end
    pixel_y = 10'd200; p_tick = 1'b1;
    @(posedge clk);
    #1;
    pause = 1'b0;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    chk("unpause_hold_x", box_x, bx0);
    frame_main();
    chk("resume_x", box_x, 32'(bx0) + 2);
    chk("resume_y", box_y, 32'(by0) + 2);

    // Small field: walk into the bottom-right corner, then top-left.
    for (int f = 0; f < 6; f++) begin
      frame_small();
      chk($sformatf("corner_x%0d", f), s_bx, 32'(ex_sx[f]));
      chk($sformatf("corner_y%0d", f), s_by, 32'(ex_sy[f]));
    end

    chk("q_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
